// File: rtl/arb4ph_pkg.sv
// Shared definitions for the N-channel 4-phase arbiter.
// Holds the FSM state type, the arbitration mode codes and the winner-select
// function used in IDLE. Nothing here has ports.
package arb4ph_pkg;

    typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} arb_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int MAX_CH    = 32;

    // Returns the index of the first set bit of vec among the low n_ch bits.
    // rr=0: search starts at 0. rr=1: search starts at ptr and wraps at n_ch.
    // Callers only rely on the result when vec has at least one bit set.
    function automatic logic [4:0] pick_winner(input logic [MAX_CH-1:0] vec,
                                               input logic [4:0]        ptr,
                                               input int                n_ch,
                                               input logic              rr);
        logic       found;
        logic [4:0] idx;
        int         j;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            j = rr ? int'(ptr) + i : i;
            if (j >= n_ch) j = j - n_ch;
            if (i < n_ch && !found && vec[j]) begin
                found = 1'b1;
                idx   = 5'(j);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/sync_ff_n.sv
// W-bit flip-flop synchroniser, STAGES deep; a plain wire when STAGES is 0.
// Ports: clk, rst (sync, active high, clears every stage), d (async in),
//        q (d delayed STAGES cycles).
module sync_ff_n #(
    parameter int W      = 1,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (STAGES == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_sync
            logic [W-1:0] stg_q [STAGES];
            logic [W-1:0] stg_d [STAGES];

            always_comb begin
                stg_d[0] = d;
                for (int i = 1; i < STAGES; i++) stg_d[i] = stg_q[i-1];
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < STAGES; i++) begin
                    if (rst) stg_q[i] <= '0;
                    else     stg_q[i] <= stg_d[i];
                end
            end

            assign q = stg_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/arbiter_rn_4ph_sync.sv
// N-channel 4-phase request/acknowledge arbiter onto a single downstream
// channel, fixed-priority or round-robin, with optional input synchronisers.
// Ports: clk, rst (sync, active high); r/a upstream request/ack per channel;
//        r0/a0 downstream request/ack; grant_id owner index (valid when busy);
//        busy (FSM not IDLE); proto_err (sticky handshake violation).
// All outputs are registered.
module arbiter_rn_4ph_sync
    import arb4ph_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int ARB_MODE    = 1,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_CH-1:0]  r,
    output logic [N_CH-1:0]  a,
    output logic             r0,
    input  logic             a0,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy,
    output logic             proto_err
);

    logic [N_CH-1:0]   rs;
    logic              a0s;
    logic [MAX_CH-1:0] rs_ext;
    logic [IDX_W-1:0]  w_pick;

    arb_state_e        state_q, state_d;
    logic [N_CH-1:0]   a_q, a_d;
    logic              r0_q, r0_d;
    logic              busy_q, busy_d;
    logic              perr_q, perr_d;
    logic              a0s_prev_q, a0s_prev_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    sync_ff_n #(.W(N_CH), .STAGES(SYNC_STAGES)) u_sync_r (
        .clk (clk), .rst (rst), .d (r),  .q (rs)
    );

    sync_ff_n #(.W(1), .STAGES(SYNC_STAGES)) u_sync_a0 (
        .clk (clk), .rst (rst), .d (a0), .q (a0s)
    );

    always_comb begin
        rs_ext = '0;
        rs_ext[N_CH-1:0] = rs;
    end

    assign w_pick = IDX_W'(pick_winner(rs_ext, 5'(ptr_q), N_CH, ARB_MODE == ARB_RR));

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        r0_d       = r0_q;
        busy_d     = busy_q;
        perr_d     = perr_q;
        grant_id_d = grant_id_q;
        ptr_d      = ptr_q;
        a0s_prev_d = a0s;

        case (state_q)
            IDLE: begin
                // Downstream acking with nothing outstanding.
                if (a0s) perr_d = 1'b1;
                if (|rs) begin
                    grant_id_d = w_pick;
                    r0_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = REQ;
                    if (ARB_MODE == ARB_RR)
                        ptr_d = (w_pick == IDX_W'(N_CH - 1)) ? '0 : w_pick + 1'b1;
                end
            end
            REQ: begin
                // Winner withdrew, or a0 dropped without ever acking this grant.
                if (!rs[grant_id_q])       perr_d = 1'b1;
                if (a0s_prev_q && !a0s)    perr_d = 1'b1;
                if (a0s) begin
                    a_d             = '0;
                    a_d[grant_id_q] = 1'b1;
                    state_d         = ACK;
                end
            end
            ACK: begin
                // a0 is high on entry, so any low sample here is a fall.
                if (!a0s) perr_d = 1'b1;
                if (!rs[grant_id_q]) begin
                    r0_d    = 1'b0;
                    state_d = RTZ;
                end
            end
            RTZ: begin
                if (!a0s) begin
                    a_d     = '0;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            r0_q       <= 1'b0;
            busy_q     <= 1'b0;
            perr_q     <= 1'b0;
            a0s_prev_q <= 1'b0;
            grant_id_q <= '0;
            ptr_q      <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            r0_q       <= r0_d;
            busy_q     <= busy_d;
            perr_q     <= perr_d;
            a0s_prev_q <= a0s_prev_d;
            grant_id_q <= grant_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign a         = a_q;
    assign r0        = r0_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;
    assign grant_id  = grant_id_q;

endmodule
